// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with per-register busy scoreboard
//
// Purpose: integer register file with NRead asynchronous read ports, NWrite
// write ports, optional same-cycle write-to-read bypass and a busy scoreboard.
// Register 0 reads as zero and is never busy.
//
// Ports:
//   clk_i        clock, all state updates on rising edge
//   rst_ni       asynchronous active-low reset
//   raddr_i      NRead read addresses
//   rdata_o      NRead read data (combinational)
//   rbusy_o      NRead busy flags of addressed registers (combinational)
//   we_i         NWrite write enables
//   waddr_i      NWrite write addresses
//   wdata_i      NWrite write data
//   rsv_valid_i  reserve request, sets busy[rsv_addr_i]
//   rsv_addr_i   register to reserve
//   flush_i      clear all busy bits
//   busy_o       registered busy vector, bit 0 always 0
module regfile_sb #(
   parameter int XLen        = 32,
   parameter int NReg        = 32,
   parameter int NRead       = 2,
   parameter int NWrite      = 1,
   parameter int WriteBypass = 1,
   localparam int NRegWidth  = $clog2(NReg)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NRead-1:0][NRegWidth-1:0]   raddr_i,
   output logic [NRead-1:0][XLen-1:0]        rdata_o,
   output logic [NRead-1:0]                  rbusy_o,
   input  logic [NWrite-1:0]                 we_i,
   input  logic [NWrite-1:0][NRegWidth-1:0]  waddr_i,
   input  logic [NWrite-1:0][XLen-1:0]       wdata_i,
   input  logic                              rsv_valid_i,
   input  logic [NRegWidth-1:0]              rsv_addr_i,
   input  logic                              flush_i,
   output logic [NReg-1:0]                   busy_o
);

   logic [XLen-1:0]             regs [NReg-1:1];
   logic [NReg-1:0][XLen-1:0]   rf;
   logic [NReg-1:0]             busy_q;
   logic [NReg-1:0]             busy_d;
   logic [NReg-1:0]             wr_hit;
   logic [NReg-1:0][XLen-1:0]   wr_data;

   // Resolve write ports per register; ascending loop lets the highest port win.
   always_comb begin
      wr_hit  = '0;
      wr_data = '0;
      for (int p = 0; p < NWrite; p++) begin
         if (we_i[p] && waddr_i[p] != '0) begin
            wr_hit[waddr_i[p]]  = 1'b1;
            wr_data[waddr_i[p]] = wdata_i[p];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 1; r < NReg; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NReg; r++) begin
            if (wr_hit[r]) begin
               regs[r] <= wr_data[r];
            end
         end
      end
   end

   // Busy priority per bit: flush, then reserve, then write-back clear, then hold.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NReg; r++) begin
         if (flush_i) begin
            busy_d[r] = 1'b0;
         end else if (rsv_valid_i && rsv_addr_i == NRegWidth'(r)) begin
            busy_d[r] = 1'b1;
         end else if (wr_hit[r]) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

   // Flat view with a constant zero at index 0 so reads need no special case.
   always_comb begin
      rf    = '0;
      for (int r = 1; r < NReg; r++) begin
         rf[r] = regs[r];
      end
   end

   // Bypass is gated by reset so that outputs stay zero while reset is held.
   always_comb begin
      rdata_o = '0;
      rbusy_o = '0;
      for (int q = 0; q < NRead; q++) begin
         rdata_o[q] = rf[raddr_i[q]];
         rbusy_o[q] = busy_q[raddr_i[q]];
         if (WriteBypass != 0 && rst_ni && raddr_i[q] != '0) begin
            for (int p = 0; p < NWrite; p++) begin
               if (we_i[p] && waddr_i[p] == raddr_i[q]) begin
                  rdata_o[q] = wdata_i[p];
                  rbusy_o[q] = 1'b0;
               end
            end
         end
      end
   end

endmodule
